// File: rtl/alu_writeback.sv
// alu_writeback: registered result/flag buffer that sits after the 16-bit ALU adder.
// It holds the sum and the five status flags in a small valid/ready FIFO.
// It also tracks a sticky overflow bit and counts the results it delivers.
module alu_writeback #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_z,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_parity,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_z,
  output logic [4:0]       out_flags,
  output logic             sticky_ovf,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] result_count
);

  localparam int unsigned ZW = 16;
  localparam int unsigned FW = 5;
  localparam int unsigned EW = ZW + FW;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  // Reject DEPTH values that break the power-of-two pointer wrap.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_writeback: DEPTH must be a power of two in 2..16");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nxt_c;
  logic          push_c;
  logic          pop_c;
  logic [FW-1:0] in_flags_c;
  logic [EW-1:0] head_c;

  assign in_flags_c = {in_overflow, in_parity, in_carry, in_zero, in_sign};
  assign push_c     = in_valid & in_ready;
  assign pop_c      = out_valid & out_ready;
  assign head_c     = mem[rd_ptr];

  // The head entry is already a register, so the outputs are taken straight from it.
  assign out_z     = head_c[ZW-1:0];
  assign out_flags = head_c[EW-1:ZW];

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    occ_nxt_c = occ;
    case ({push_c, pop_c})
      2'b10:   occ_nxt_c = occ + OW'(1);
      2'b01:   occ_nxt_c = occ - OW'(1);
      default: occ_nxt_c = occ;
    endcase
  end

  // Pointers, occupancy and the registered ready/valid handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      occ       <= occ_nxt_c;
      in_ready  <= (occ_nxt_c < OW'(DEPTH));
      out_valid <= (occ_nxt_c != '0);
    end
  end

  // Entry storage; cleared on reset so no stale result is ever presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= {in_flags_c, in_z};
    end
  end

  // Sticky overflow: a popped overflow result beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (pop_c && out_flags[4]) begin
      sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf <= 1'b0;
    end
  end

  // Delivered-result counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count <= '0;
    end else if (pop_c) begin
      result_count <= result_count + CNT_W'(1);
    end
  end

  // Structural sanity properties.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && occ == OW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_c && occ == '0));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= OW'(DEPTH));

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: queue-based reference model plus directed literal checks.
module tb_alu_writeback;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_z;
  logic [4:0]       fl;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_z;
  logic [4:0]       out_flags;
  logic             sticky_ovf;
  logic             sticky_clr;
  logic [CNT_W-1:0] result_count;

  alu_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_sign(fl[0]), .in_zero(fl[1]), .in_carry(fl[2]), .in_parity(fl[3]), .in_overflow(fl[4]),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr), .result_count(result_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {flags, z}, the sticky bit, a counter and a "ready since reset" flag.
  logic [20:0] mq[$];
  logic        m_alive;
  logic        m_sticky;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_alive  = 1'b0;
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else begin
      logic acc;
      logic [20:0] head;
      acc = in_valid && m_alive && (mq.size() < int'(DEPTH));
      if (out_ready && mq.size() != 0) begin
        head = mq.pop_front();
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (head[20]) m_sticky = 1'b1;
        else if (sticky_clr) m_sticky = 1'b0;
      end else if (sticky_clr) begin
        m_sticky = 1'b0;
      end
      if (acc) mq.push_back({fl, in_z});
      m_alive = 1'b1;
    end
  end

  // Literal expectations queued by the stimulus, checked at the next falling edge.
  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } lit_t;
  lit_t lq[$];

  int checks = 0;
  int errors = 0;

  task automatic expect_lit(input int sig, input logic [31:0] exp, input string name);
    lit_t l;
    l.sig = sig; l.exp = exp; l.name = name;
    lq.push_back(l);
  endtask

  // Single compare process: model checks every cycle, then any queued literal checks.
  always @(negedge clk) begin
    logic [31:0] act;
    logic        m_ready;
    m_ready = m_alive && (mq.size() < int'(DEPTH));
    checks++;
    if (in_ready !== m_ready) begin
      errors++; $display("FAIL model in_ready got %0b want %0b t=%0t", in_ready, m_ready, $time);
    end
    checks++;
    if (out_valid !== (mq.size() != 0)) begin
      errors++; $display("FAIL model out_valid got %0b want %0b t=%0t", out_valid, mq.size() != 0, $time);
    end
    checks++;
    if (int'(result_count) != m_cnt || $isunknown(result_count)) begin
      errors++; $display("FAIL model result_count got %0d want %0d t=%0t", result_count, m_cnt, $time);
    end
    checks++;
    if (sticky_ovf !== m_sticky) begin
      errors++; $display("FAIL model sticky_ovf got %0b want %0b t=%0t", sticky_ovf, m_sticky, $time);
    end
    if (mq.size() != 0) begin
      checks++;
      if ({out_flags, out_z} !== mq[0]) begin
        errors++; $display("FAIL model head got %h/%h want %h/%h t=%0t",
                           out_flags, out_z, mq[0][20:16], mq[0][15:0], $time);
      end
    end
    while (lq.size() != 0) begin
      lit_t l;
      l = lq.pop_front();
      case (l.sig)
        0:       act = 32'(in_ready);
        1:       act = 32'(out_valid);
        2:       act = 32'(out_z);
        3:       act = 32'(out_flags);
        4:       act = 32'(sticky_ovf);
        default: act = 32'(result_count);
      endcase
      checks++;
      if (act !== l.exp) begin
        errors++; $display("FAIL %s got %0h want %0h t=%0t", l.name, act, l.exp, $time);
      end
    end
  end

  localparam int S_RDY = 0, S_VLD = 1, S_Z = 2, S_FL = 3, S_STK = 4, S_CNT = 5;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [15:0] z, input logic [4:0] f,
                       input logic ordy, input logic clr);
    in_valid = v; in_z = z; fl = f; out_ready = ordy; sticky_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    tick();
    expect_lit(S_RDY, 0, "reset_in_ready");
    expect_lit(S_VLD, 0, "reset_out_valid");
    expect_lit(S_Z, 0, "reset_out_z");
    expect_lit(S_FL, 0, "reset_out_flags");
    expect_lit(S_STK, 0, "reset_sticky");
    expect_lit(S_CNT, 0, "reset_count");
    rst_n = 1'b1;
    tick();
    expect_lit(S_RDY, 1, "ready_after_release");

    // 7FFF + 0001 -> 8000, sign and overflow.
    drive(1'b1, 16'h8000, 5'b10001, 1'b1, 1'b0);
    tick();
    expect_lit(S_VLD, 1, "push_valid");
    expect_lit(S_Z, 32'h8000, "push_z");
    expect_lit(S_FL, 32'h11, "push_flags");
    expect_lit(S_CNT, 0, "push_count_before_pop");
    drive(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    expect_lit(S_STK, 1, "pop_sticky_set");
    expect_lit(S_CNT, 1, "pop_count");

    // FFFF + 0001 -> 0000, carry/zero/parity.
    drive(1'b1, 16'h0000, 5'b01110, 1'b0, 1'b0);
    tick();
    expect_lit(S_FL, 32'h0e, "carry_zero_flags");
    drive(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    expect_lit(S_STK, 1, "carry_zero_sticky_unchanged");
    expect_lit(S_CNT, 2, "carry_zero_count");

    // Backpressure with a full buffer.
    drive(1'b1, 16'h1234, 5'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h5678, 5'h0, 1'b0, 1'b0);
    tick();
    expect_lit(S_RDY, 0, "full_not_ready");
    expect_lit(S_Z, 32'h1234, "full_head_a");
    drive(1'b1, 16'h9999, 5'h0, 1'b0, 1'b0);
    tick();
    expect_lit(S_Z, 32'h1234, "stall_head_hold");
    drive(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    expect_lit(S_Z, 32'h5678, "drain_head_b");
    expect_lit(S_RDY, 1, "ready_after_first_pop");
    tick();
    expect_lit(S_VLD, 0, "drained_empty");
    expect_lit(S_CNT, 4, "drained_count");

    // Full, push and pop together: pop proceeds, push blocked.
    drive(1'b1, 16'h1111, 5'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 5'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h3333, 5'h0, 1'b1, 1'b0);
    tick();
    expect_lit(S_Z, 32'h2222, "full_pushpop_head");
    expect_lit(S_CNT, 5, "full_pushpop_count");
    drive(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    expect_lit(S_VLD, 0, "full_pushpop_no_third");

    // Sticky clear racing an overflow pop.
    drive(1'b0, 16'h0, 5'h0, 1'b0, 1'b1);
    tick();
    expect_lit(S_STK, 0, "lone_clear");
    drive(1'b1, 16'h8000, 5'b10001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 5'h0, 1'b1, 1'b1);
    tick();
    expect_lit(S_STK, 1, "set_beats_clear");
    expect_lit(S_CNT, 7, "set_beats_clear_count");
    drive(1'b0, 16'h0, 5'h0, 1'b0, 1'b1);
    tick();
    expect_lit(S_STK, 0, "clear_after_set");

    // Streaming at one result per cycle through the 4-bit counter wrap.
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, 16'($urandom), 5'($urandom), 1'b1, 1'b0);
      tick();
      expect_lit(S_VLD, 1, "stream_valid");
      expect_lit(S_RDY, 1, "stream_ready");
      if (i == 9)  expect_lit(S_CNT, 15, "wrap_15");
      if (i == 10) expect_lit(S_CNT, 0, "wrap_0");
      if (i == 11) expect_lit(S_CNT, 1, "wrap_1");
    end

    // Reset mid-stream with two entries held.
    drive(1'b1, 16'hAAAA, 5'b10000, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_lit(S_VLD, 0, "midreset_valid");
    expect_lit(S_CNT, 0, "midreset_count");
    expect_lit(S_STK, 0, "midreset_sticky");
    expect_lit(S_RDY, 0, "midreset_ready");
    tick();
    rst_n = 1'b1;
    tick();
    expect_lit(S_RDY, 1, "midreset_ready_after");
    expect_lit(S_VLD, 0, "midreset_no_stale");
    expect_lit(S_Z, 0, "midreset_z_cleared");

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    drive(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Registered result/flag stage directly downstream of the 16-bit ALU adder. It captures the sum Z and the five status flags (Sign, Zero, Carry, Parity, Overflow) into a small valid/ready buffer, then presents them to the register-file/branch stage. It also keeps a sticky overflow flag and a count of delivered results.

Parameters:
- DEPTH, 2, number of buffer entries; legal values are powers of two from 2 to 16.
- CNT_W, 16, width of result_count.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_z  input  16  ALU sum Z.
- in_sign  input  1  ALU Sign flag.
- in_zero  input  1  ALU Zero flag.
- in_carry  input  1  ALU Carry flag.
- in_parity  input  1  ALU Parity flag (even parity, 1 when Z has an even number of ones).
- in_overflow  input  1  ALU signed Overflow flag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- out_z  output  16  head entry sum.
- out_flags  output  5  head entry flags packed {overflow, parity, carry, zero, sign}, bit 4 down to bit 0.
- sticky_ovf  output  1  set when any delivered result had overflow.
- sticky_clr  input  1  clears sticky_ovf.
- result_count  output  CNT_W  number of delivered results.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Occupancy = 0; read and write pointers = 0.
  - out_valid = 0, out_z = 0, out_flags = 0, sticky_ovf = 0, result_count = 0.
  - in_ready = 1 one cycle after rst_n deasserts; in_ready is 0 while rst_n is 0.
  - Reset mid-operation flushes all entries with no output. Stored data is lost.
- Push: in_valid & in_ready at a rising edge writes {in_z, packed flags} at the write pointer. The write pointer increments modulo DEPTH.
- Pop: out_valid & out_ready at a rising edge advances the read pointer modulo DEPTH.
- in_ready = (occupancy < DEPTH), driven from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). out_z and out_flags come straight from the head entry, registered with no combinational path from in_*.
- Latency: a result accepted at edge N is visible on out_* after edge N, i.e. in the next cycle. There is no bypass.
- Boundary conditions:
  - Full, with push and pop in the same cycle: the push is blocked because in_ready=0; the pop proceeds, and in_ready rises the next cycle.
  - Empty, with in_valid=1: the push proceeds; out_valid rises the next cycle, and out_ready in the current cycle is ignored.
  - Partially full, with push and pop in the same cycle: occupancy is unchanged and both pointers advance.
  - While out_valid=1 and out_ready=0, out_z and out_flags hold stable.
- Flags are stored exactly as presented. This stage does not recompute any flag.
- sticky_ovf:
  - Set on a pop whose head out_flags[4]=1.
  - Cleared by sticky_clr=1 at an edge.
  - If a set and a clear occur in the same cycle, the set wins and sticky_ovf=1.
- result_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0 with no saturation.
- There is no explicit FSM. Occupancy states are EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH):
  - EMPTY to PARTIAL on a push.
  - PARTIAL to FULL on a push without a pop when occupancy reaches DEPTH.
  - FULL to PARTIAL on a pop.
  - PARTIAL to EMPTY on a pop without a push when occupancy reaches 0.
- Asserts (verification):
  - No push while full.
  - No pop while empty.
  - Occupancy never exceeds DEPTH.

Test Plan:
- Reset mid-stream with 2 entries held: assert rst_n=0 for 1 cycle. Required response: out_valid=0 immediately, result_count=0, sticky_ovf=0, no stale data after release, in_ready=1 one cycle later.
- Single push: in_z=16'h8000 with sign=1, overflow=1, others 0 (from 7FFF+0001), out_ready=1. Required response:
  - Next cycle: out_valid=1, out_z=16'h8000, out_flags=5'b10001.
  - After that pop: sticky_ovf=1, result_count=1.
- Carry/zero result: in_z=16'h0000 with carry=1, zero=1, parity=1, others 0 (from FFFF+0001). Required response: out_flags=5'b01110 and sticky_ovf unchanged.
- Backpressure with DEPTH=2 and out_ready=0: push A=16'h1234 and B=16'h5678. Required response:
  - in_ready=0 after the second push; a third in_valid is not accepted.
  - out_z holds 16'h1234.
  - Raise out_ready: outputs are A then B in order, and in_ready returns to 1 the cycle after the first pop.
- Concurrent sticky clear: in the same cycle, pop an entry with overflow=1 and assert sticky_clr=1. Required response: sticky_ovf=1. A lone sticky_clr in the following cycle gives sticky_ovf=0.
- Counter wrap: with CNT_W=4, stream 17 results at one per cycle with out_ready=1. Required response: result_count reads 15 then 0 then 1, with no data loss and one result per cycle sustained throughput.
